// File: rtl/issue_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : issue_decoder
//  Purpose  : Handshaked GPGPU instruction decoder with a main + skid entry
//             buffer and a post-RET intake halt that only flush/reset clear.
//  Options  : ISSUE_DECODER_FP_EN - when defined, float ALU/CONST/GEMM/SETP
//             opcodes decode normally; otherwise they decode as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_decoder #(
  parameter int REG_ADDR_BITS  = 8,
  parameter int IMM_BITS       = 8,
  parameter int PRED_ADDR_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_ADDR_BITS-1:0]  rd_addr,
  output logic [REG_ADDR_BITS-1:0]  rs_addr,
  output logic [REG_ADDR_BITS-1:0]  rt_addr,
  output logic [IMM_BITS-1:0]       immediate,
  output logic [PRED_ADDR_BITS-1:0] pred_addr,
  output logic                      reg_we,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic                      pred_we,
  output logic                      pred_on,
  output logic                      always_exec,
  output logic                      ret,
  output logic                      fp_op,
  output logic                      mat_op,
  output logic                      illegal,
  output logic [1:0]                reg_input_mux,
  output logic [1:0]                alu_op,
  output logic                      alu_output_mux,
  output logic [1:0]                cmp_mode
);

`ifdef ISSUE_DECODER_FP_EN
  localparam logic c_fp_en = 1'b1;
`else
  localparam logic c_fp_en = 1'b0;
`endif

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0]  rd;
    logic [REG_ADDR_BITS-1:0]  rs;
    logic [REG_ADDR_BITS-1:0]  rt;
    logic [IMM_BITS-1:0]       imm;
    logic [PRED_ADDR_BITS-1:0] pred;
    logic                      reg_we;
    logic                      mem_re;
    logic                      mem_we;
    logic                      pred_we;
    logic                      pred_on;
    logic                      always_exec;
    logic                      ret;
    logic                      fp_op;
    logic                      mat_op;
    logic                      illegal;
    logic [1:0]                mux;
    logic [1:0]                alu_op;
    logic                      alu_out_mux;
    logic [1:0]                cmp_mode;
  } bundle_t;

  logic [5:0] w_op;
  logic       w_is_alu, w_is_ld, w_is_st, w_is_const, w_is_gemm, w_is_setp, w_is_ret;
  logic       w_fp_blocked;
  bundle_t    w_dec;

  bundle_t    r_main, r_skid, w_main_n, w_skid_n;
  logic       r_main_v, r_skid_v, r_halted, r_in_ready;
  logic       w_main_v_n, w_skid_v_n, w_halted_n;
  logic       w_push, w_pop;

  // Opcode classes: bit 5 = predicated, bit 4 = float/matrix, [3:0] = family.
  assign w_op       = instruction[31:26];
  assign w_is_alu   = (w_op[3:2] == 2'b00) && (w_op[1:0] != 2'b11);
  assign w_is_ld    = !w_op[5] && (w_op[3:0] == 4'b0100);
  assign w_is_st    = !w_op[5] && (w_op[3:0] == 4'b0101);
  assign w_is_const = (w_op[3:0] == 4'b0110);
  assign w_is_gemm  = !w_op[5] && (w_op[3:0] == 4'b0111);
  assign w_is_setp  = !w_op[5] && (w_op[3:2] == 2'b11) && (w_op[1:0] != 2'b00);
  assign w_is_ret   = (w_op == 6'b111111);
  // Float variants of the arithmetic families need the FP datapath; loads and
  // stores reuse bit 4 as the matrix flag and are never blocked.
  assign w_fp_blocked = w_op[4] && !c_fp_en &&
                        (w_is_alu || w_is_const || w_is_gemm || w_is_setp);

  // Decode the incoming word into a control bundle; fields always pass through.
  always_comb begin
    w_dec      = '0;
    w_dec.rd   = instruction[16 +: REG_ADDR_BITS];
    w_dec.rs   = instruction[8 +: REG_ADDR_BITS];
    w_dec.rt   = instruction[0 +: REG_ADDR_BITS];
    w_dec.imm  = instruction[0 +: IMM_BITS];
    w_dec.pred = instruction[24 +: PRED_ADDR_BITS];
    if (w_fp_blocked) begin
      w_dec.illegal = 1'b1;
    end else if (w_is_alu) begin
      w_dec.reg_we  = 1'b1;
      w_dec.pred_on = w_op[5];
      w_dec.fp_op   = c_fp_en & w_op[4];
      w_dec.alu_op  = w_op[1:0];
    end else if (w_is_ld) begin
      w_dec.reg_we      = 1'b1;
      w_dec.mem_re      = 1'b1;
      w_dec.mux         = 2'b01;
      w_dec.always_exec = 1'b1;
      w_dec.mat_op      = w_op[4];
    end else if (w_is_st) begin
      w_dec.mem_we      = 1'b1;
      w_dec.always_exec = 1'b1;
      w_dec.mat_op      = w_op[4];
    end else if (w_is_const) begin
      w_dec.reg_we  = 1'b1;
      w_dec.mux     = 2'b10;
      w_dec.pred_on = w_op[5];
      w_dec.fp_op   = c_fp_en & w_op[4];
    end else if (w_is_gemm) begin
      w_dec.reg_we      = 1'b1;
      w_dec.mux         = 2'b11;
      w_dec.always_exec = 1'b1;
      w_dec.fp_op       = c_fp_en & w_op[4];
    end else if (w_is_setp) begin
      w_dec.pred_we     = 1'b1;
      w_dec.alu_out_mux = 1'b1;
      w_dec.always_exec = 1'b1;
      w_dec.fp_op       = c_fp_en & w_op[4];
      w_dec.cmp_mode    = w_op[1:0] - 2'b01;
    end else if (w_is_ret) begin
      w_dec.ret         = 1'b1;
      w_dec.always_exec = 1'b1;
    end else begin
      w_dec.illegal = 1'b1;
    end
  end

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_main_v && out_ready;

  // Buffer next state: pop before push, skid refills main, flush wins over all.
  always_comb begin
    w_main_n   = r_main;
    w_skid_n   = r_skid;
    w_main_v_n = r_main_v;
    w_skid_v_n = r_skid_v;
    w_halted_n = r_halted;
    if (flush) begin
      w_main_v_n = 1'b0;
      w_skid_v_n = 1'b0;
      w_halted_n = 1'b0;
    end else begin
      if (w_pop) begin
        // A full skid implies in_ready was low, so no push can coincide here.
        if (r_skid_v) begin
          w_main_n   = r_skid;
          w_skid_v_n = 1'b0;
        end else if (w_push) begin
          w_main_n = w_dec;
        end else begin
          w_main_v_n = 1'b0;
        end
      end else if (w_push) begin
        if (!r_main_v) begin
          w_main_n   = w_dec;
          w_main_v_n = 1'b1;
        end else begin
          w_skid_n   = w_dec;
          w_skid_v_n = 1'b1;
        end
      end
      if (w_push && w_dec.ret) begin
        w_halted_n = 1'b1;
      end
    end
  end

  // State registers; in_ready comes from next state so it never sees inputs
  // combinationally, and is high straight out of reset so fetch can start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_halted   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_main     <= w_main_n;
      r_skid     <= w_skid_n;
      r_main_v   <= w_main_v_n;
      r_skid_v   <= w_skid_v_n;
      r_halted   <= w_halted_n;
      r_in_ready <= !w_skid_v_n && !w_halted_n;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_v;
  assign rd_addr        = r_main.rd;
  assign rs_addr        = r_main.rs;
  assign rt_addr        = r_main.rt;
  assign immediate      = r_main.imm;
  assign pred_addr      = r_main.pred;
  assign reg_we         = r_main.reg_we;
  assign mem_re         = r_main.mem_re;
  assign mem_we         = r_main.mem_we;
  assign pred_we        = r_main.pred_we;
  assign pred_on        = r_main.pred_on;
  assign always_exec    = r_main.always_exec;
  assign ret            = r_main.ret;
  assign fp_op          = r_main.fp_op;
  assign mat_op         = r_main.mat_op;
  assign illegal        = r_main.illegal;
  assign reg_input_mux  = r_main.mux;
  assign alu_op         = r_main.alu_op;
  assign alu_output_mux = r_main.alu_out_mux;
  assign cmp_mode       = r_main.cmp_mode;

endmodule
`default_nettype wire

// File: tb/tb_issue_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_decoder
//  Purpose  : Self-checking bench for issue_decoder: decode vector table,
//             hand-written stall/halt/flush/reset sequences and a randomized
//             run against a transaction-level queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_decoder;

`ifdef ISSUE_DECODER_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_ready, out_valid;
  logic [7:0]  rd_addr, rs_addr, rt_addr, immediate;
  logic [1:0]  pred_addr, reg_input_mux, alu_op, cmp_mode;
  logic        reg_we, mem_re, mem_we, pred_we, pred_on, always_exec, ret;
  logic        fp_op, mat_op, illegal, alu_output_mux;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_decoder #(.REG_ADDR_BITS(8), .IMM_BITS(8), .PRED_ADDR_BITS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .immediate(immediate), .pred_addr(pred_addr),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .pred_we(pred_we),
    .pred_on(pred_on), .always_exec(always_exec), .ret(ret), .fp_op(fp_op),
    .mat_op(mat_op), .illegal(illegal), .reg_input_mux(reg_input_mux),
    .alu_op(alu_op), .alu_output_mux(alu_output_mux), .cmp_mode(cmp_mode)
  );

  // flag order: reg_we mem_re mem_we pred_we pred_on always_exec ret fp_op
  //             mat_op illegal | reg_input_mux alu_op alu_output_mux cmp_mode
  function automatic logic [16:0] dut_flags();
    return {reg_we, mem_re, mem_we, pred_we, pred_on, always_exec, ret, fp_op,
            mat_op, illegal, reg_input_mux, alu_op, alu_output_mux, cmp_mode};
  endfunction

  function automatic logic [33:0] dut_fields();
    return {rd_addr, rs_addr, rt_addr, immediate, pred_addr};
  endfunction

  function automatic logic [50:0] dut_bundle();
    return {dut_fields(), dut_flags()};
  endfunction

  // Reference decode: enumerate the opcode map into instruction classes.
  // classes: 0 illegal, 1 alu, 2 load, 3 store, 4 const, 5 gemm, 6 setp, 7 ret
  function automatic logic [16:0] ref_flags(input logic [31:0] ins);
    logic [5:0] op;
    int         cls;
    bit         fp, pr, mat;
    logic [1:0] mux, aop, cmp;
    op = ins[31:26];
    cls = 0; fp = 0; pr = 0; mat = 0;
    case (op)
      6'b000000, 6'b000001, 6'b000010: cls = 1;
      6'b100000, 6'b100001, 6'b100010: begin cls = 1; pr = 1; end
      6'b010000, 6'b010001, 6'b010010: begin cls = 1; fp = 1; end
      6'b110000, 6'b110001, 6'b110010: begin cls = 1; fp = 1; pr = 1; end
      6'b000100: cls = 2;
      6'b010100: begin cls = 2; mat = 1; end
      6'b000101: cls = 3;
      6'b010101: begin cls = 3; mat = 1; end
      6'b000110: cls = 4;
      6'b100110: begin cls = 4; pr = 1; end
      6'b010110: begin cls = 4; fp = 1; end
      6'b110110: begin cls = 4; fp = 1; pr = 1; end
      6'b000111: cls = 5;
      6'b010111: begin cls = 5; fp = 1; end
      6'b001101, 6'b001110, 6'b001111: cls = 6;
      6'b011101, 6'b011110, 6'b011111: begin cls = 6; fp = 1; end
      6'b111111: cls = 7;
      default:   cls = 0;
    endcase
    if (fp && !FP_EN) cls = 0;
    mux = (cls == 2) ? 2'd1 : (cls == 4) ? 2'd2 : (cls == 5) ? 2'd3 : 2'd0;
    aop = (cls == 1) ? op[1:0] : 2'd0;
    cmp = (cls == 6) ? 2'(op[1:0] - 2'd1) : 2'd0;
    return {cls inside {1, 2, 4, 5}, cls == 2, cls == 3, cls == 6,
            pr && (cls inside {1, 4}), cls inside {2, 3, 5, 6, 7}, cls == 7,
            fp && (cls inside {1, 4, 5, 6}), mat && (cls != 0), cls == 0,
            mux, aop, cls == 6, cmp};
  endfunction

  function automatic logic [50:0] ref_bundle(input logic [31:0] ins);
    return {ins[23:16], ins[15:8], ins[7:0], ins[7:0], ins[25:24], ref_flags(ins)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [16:0] flags;
    string       name;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  localparam int NOPS = 26;
  logic [5:0] op_list[NOPS];

  logic [31:0] q[$];
  bit          m_halted;

  initial begin
    logic [31:0] va, vb, vc, ins;
    bit          acc, pop, iv, ordy, fl;
    int          r;

    // ---------------- decode vector table ----------------
    tbl[0]  = '{32'h00030102, 17'b1000000000_00_00_0_00, "ADD"};
    tbl[1]  = '{32'h05A1B2C3, 17'b1000000000_00_01_0_00, "SUB"};
    tbl[2]  = '{32'h8A0F1E2D, 17'b1000100000_00_10_0_00, "PMUL"};
    tbl[3]  = '{32'h11223344, 17'b1100010000_01_00_0_00, "LDR"};
    tbl[4]  = '{32'h52A5C3E7, 17'b1100010010_01_00_0_00, "MATLDR"};
    tbl[5]  = '{32'h57010203, 17'b0010010010_00_00_0_00, "MATSTR"};
    tbl[6]  = '{32'h1C0A0B0C, 17'b1000010000_11_00_0_00, "GEMM"};
    tbl[7]  = '{32'h99FF00AA, 17'b1000100000_10_00_0_00, "PCONST"};
    tbl[8]  = '{32'h3C001405, 17'b0001010000_00_00_1_10, "SETPLE"};
    tbl[9]  = '{32'h39445566, 17'b0001010000_00_00_1_01, "SETPEQ"};
    tbl[10] = '{32'h0C123456, 17'b0000000001_00_00_0_00, "ILL000011"};
`ifdef ISSUE_DECODER_FP_EN
    tbl[11] = '{32'hCA010203, 17'b1000100100_00_10_0_00, "PFMUL"};
    tbl[12] = '{32'h40070809, 17'b1000000100_00_00_0_00, "FADD"};
`else
    tbl[11] = '{32'hCA010203, 17'b0000000001_00_00_0_00, "PFMUL"};
    tbl[12] = '{32'h40070809, 17'b0000000001_00_00_0_00, "FADD"};
`endif

    op_list = '{6'b000000, 6'b000001, 6'b000010, 6'b100000, 6'b100001,
                6'b100010, 6'b010000, 6'b010001, 6'b010010, 6'b110010,
                6'b000100, 6'b010100, 6'b000101, 6'b010101, 6'b000110,
                6'b010110, 6'b100110, 6'b110110, 6'b000111, 6'b010111,
                6'b001101, 6'b001110, 6'b001111, 6'b011101, 6'b001100,
                6'b101111};

    // ---------------- reset ----------------
    repeat (3) step();
    reset = 1'b0;
    check("reset in_ready", in_ready, 1);
    step();
    check("reset out_valid", out_valid, 0);
    check("reset bundle", dut_bundle(), 0);
    check("reset in_ready held", in_ready, 1);

    // ---------------- ADD with 1-cycle latency ----------------
    in_valid = 1; instruction = 32'h00030102; out_ready = 1;
    step();
    in_valid = 0;
    check("add out_valid", out_valid, 1);
    check("add reg_we", reg_we, 1);
    check("add alu_op", alu_op, 0);
    check("add rd/rs/rt", {rd_addr, rs_addr, rt_addr}, 24'h030102);
    check("add in_ready", in_ready, 1);
    step();
    check("add drained", out_valid, 0);

    // ---------------- table of decode vectors ----------------
    for (int i = 0; i < NV; i++) begin
      in_valid = 1; instruction = tbl[i].ins; out_ready = 1;
      step();
      check($sformatf("%s valid", tbl[i].name), out_valid, 1);
      check($sformatf("%s flags", tbl[i].name), dut_flags(), tbl[i].flags);
      check($sformatf("%s fields", tbl[i].name), dut_fields(),
            {tbl[i].ins[23:16], tbl[i].ins[15:8], tbl[i].ins[7:0],
             tbl[i].ins[7:0], tbl[i].ins[25:24]});
    end
    in_valid = 0;
    step();
    check("table drained", out_valid, 0);

    // ---------------- stall: skid fill, hold, ordered release ----------------
    va = 32'h04112233; vb = 32'h88445566; vc = 32'h10778899;
    out_ready = 0; in_valid = 1; instruction = va;
    step();
    check("stall A valid", out_valid, 1);
    check("stall A bundle", dut_bundle(), ref_bundle(va));
    check("stall A in_ready", in_ready, 1);
    instruction = vb;
    step();
    check("stall skid in_ready", in_ready, 0);
    check("stall hold1", dut_bundle(), ref_bundle(va));
    instruction = vc;
    step();
    check("stall hold2", dut_bundle(), ref_bundle(va));
    check("stall C refused", in_ready, 0);
    out_ready = 1;
    step();
    check("release B", dut_bundle(), ref_bundle(vb));
    check("release in_ready", in_ready, 1);
    step();
    check("release C valid", out_valid, 1);
    check("release C", dut_bundle(), ref_bundle(vc));
    in_valid = 0;
    step();
    check("release drained", out_valid, 0);

    // ---------------- RET halts intake until flush ----------------
    out_ready = 0; in_valid = 1; instruction = 32'hFC000000;
    step();
    check("ret valid", out_valid, 1);
    check("ret flag", ret, 1);
    check("ret always_exec", always_exec, 1);
    check("ret halts", in_ready, 0);
    instruction = 32'h00030102;
    step();
    check("halted in_ready", in_ready, 0);
    out_ready = 1;
    step();
    check("ret popped", out_valid, 0);
    check("halt persists", in_ready, 0);
    step();
    check("halt no intake", out_valid, 0);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("flush clears halt", in_ready, 1);
    check("flush out_valid", out_valid, 0);

    // ---------------- flush with skid full and a concurrent input ----------------
    out_ready = 0; in_valid = 1; instruction = va;
    step();
    instruction = vb;
    step();
    check("skid full", in_ready, 0);
    flush = 1; out_ready = 1; instruction = vc;
    step();
    flush = 0; in_valid = 0;
    check("flush full valid", out_valid, 0);
    check("flush full in_ready", in_ready, 1);
    step();
    check("flush full discard", out_valid, 0);

    // flush while in_ready=1: the concurrent input is dropped too
    out_ready = 0; in_valid = 1; instruction = va;
    step();
    flush = 1; out_ready = 1; instruction = vb;
    step();
    flush = 0; in_valid = 0;
    check("flush accept valid", out_valid, 0);
    step();
    check("flush accept discard", out_valid, 0);

    // ---------------- reset mid-stall ----------------
    out_ready = 0; in_valid = 1; instruction = va;
    step();
    instruction = vb;
    step();
    reset = 1;
    step();
    reset = 0; in_valid = 0;
    check("rst stall valid", out_valid, 0);
    check("rst stall in_ready", in_ready, 1);
    check("rst stall bundle", dut_bundle(), 0);
    step();
    check("rst stall empty", out_valid, 0);

    // ---------------- randomized run against a queue model ----------------
    q.delete();
    m_halted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 40) == 0;
      r    = $urandom % 20;
      ins  = $urandom;
      if (r == 0)      ins[31:26] = 6'b111111;
      else if (r != 1) ins[31:26] = op_list[$urandom % NOPS];
      in_valid = iv; out_ready = ordy; flush = fl; instruction = ins;

      acc = iv && (q.size() < 2) && !m_halted;
      pop = (q.size() != 0) && ordy;
      if (fl) begin
        q.delete();
        m_halted = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          q.push_back(ins);
          if (ins[31:26] == 6'b111111) m_halted = 1;
        end
      end
      step();
      check("rnd out_valid", out_valid, q.size() != 0);
      check("rnd in_ready", in_ready, (q.size() < 2) && !m_halted);
      if (q.size() != 0) check("rnd bundle", dut_bundle(), ref_bundle(q[0]));
    end
    in_valid = 0; flush = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
